frogger_key_move: RTL and testbench
===================================

FROGGER_KEY_MOVE -- requirements
Module: frogger_key_move

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 25000000: cycles a key is held before auto-repeat starts (0.5 s at 50 MHz); legal range 2..2^25-1.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 10000000: cycles between auto-repeat moves; legal range 2..2^25-1.
REQ-003 SHALL have port clk_clk, input, 1 bit: single system clock, same clock as the Nios keycode PIO; all logic on its rising edge.
REQ-004 SHALL have port reset_reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port keycode_export, input, 16 bits: two USB HID usage codes, byte0=[7:0], byte1=[15:8]; 0x00 means no key.
REQ-006 SHALL have port move_valid, output, 1 bit: FIFO head holds a move.
REQ-007 SHALL have port move_dir, output, 2 bits: head move; 00=UP, 01=DOWN, 10=LEFT, 11=RIGHT.
REQ-008 SHALL have port move_ready, input, 1 bit: consumer accepts head when move_valid & move_ready.
REQ-009 SHALL have port fifo_count, output, 3 bits: queued moves, 0..4.
REQ-010 SHALL have port overflow, output, 1 bit: sticky, set when a move is dropped.
REQ-011 SHALL have port clear_ovf, input, 1 bit: synchronous clear of overflow.

Function
REQ-012 SHALL register keycode_export every cycle into a sample register; all decode uses the sampled value.
REQ-013 SHALL decode a direction as active when either byte equals W=0x1A (UP), S=0x16 (DOWN), A=0x04 (LEFT), D=0x07 (RIGHT).
REQ-014 SHALL resolve multiple active directions by priority UP > DOWN > LEFT > RIGHT; the result cur_dir is one direction or NONE.
REQ-015 SHALL implement FSM states IDLE, HELD, REPEAT with one 25-bit counter cnt and a latched direction ldir.
REQ-016 IDLE: cur_dir != NONE -> emit cur_dir, ldir<=cur_dir, cnt<=0, go HELD; else stay.
REQ-017 HELD: cur_dir==NONE -> IDLE; cur_dir!=ldir -> emit cur_dir, ldir<=cur_dir, cnt<=0, stay HELD; cnt==HOLD_CYCLES-1 -> emit ldir, cnt<=0, go REPEAT; else cnt<=cnt+1.
REQ-018 REPEAT: same as HELD, with REPEAT_CYCLES in place of HOLD_CYCLES, and stay REPEAT on timeout; a direction change returns to HELD.
REQ-019 emit SHALL be a single-cycle push into a 4-entry FIFO of 2-bit directions.
REQ-020 Latency: keycode_export presented before edge k -> sampled at edge k -> push at edge k+1 -> move_valid=1 and move_dir valid after edge k+1 when the FIFO was empty.
REQ-021 Pop SHALL occur on an edge where move_valid & move_ready; move_dir and move_valid SHALL NOT change while move_valid=1 and move_ready=0.
REQ-022 Push when fifo_count==4 without a simultaneous pop SHALL drop the move and set overflow; contents unchanged.
REQ-023 Push and pop on the same edge SHALL both take effect at any count 1..4; fifo_count unchanged.
REQ-024 Pop with empty FIFO SHALL have no effect.
REQ-025 FIFO pointers SHALL be 2-bit and wrap modulo 4.
REQ-026 Same-edge set and clear_ovf SHALL leave overflow=1 (set wins).
REQ-027 A keycode byte outside the four codes SHALL be ignored; key release on both bytes SHALL return the FSM to IDLE without emitting.

Reset
REQ-028 reset_reset_n=0 SHALL asynchronously force: FSM=IDLE, cnt=0, ldir=00, sample register=0x0000, FIFO empty, move_valid=0, move_dir=00, fifo_count=0, overflow=0.
REQ-029 Reset mid-hold or mid-repeat SHALL discard pending timing and queued moves; after release a still-held key SHALL emit again as a fresh press (REQ-016).

Verification (bench uses HOLD_CYCLES=4, REPEAT_CYCLES=2)
REQ-030 Single press: keycode 0x001A for 3 cycles, move_ready=1 -> exactly one move UP, move_valid high one cycle, 2 cycles after apply.
REQ-031 Auto-repeat: keycode 0x1A00 held 20 cycles, move_ready=1 -> moves at offsets 2, 6, 8, 10, 12, ... (first, then +HOLD_CYCLES, then every REPEAT_CYCLES), all UP.
REQ-032 Priority/change: 0x0716 (DOWN+RIGHT) -> DOWN; change to 0x0700 -> immediate RIGHT, hold timer restarted.
REQ-033 Backpressure: move_ready=0, five distinct presses separated by release -> fifo_count=4, overflow=1, head=first move; then move_ready=1 -> four moves in press order; clear_ovf -> overflow=0.
REQ-034 Simultaneous: fifo_count=4, push and pop same edge -> fifo_count stays 4, overflow stays 0.
REQ-035 Reset mid-REPEAT with 2 queued moves -> all outputs at reset values immediately; after release, held key yields one move 2 cycles later.

Source files
------------

// File: rtl/frogger_key_move.sv
// frogger_key_move
// Turns the two-byte USB HID keycode from the Nios PIO into a stream of
// Frogger moves (UP/DOWN/LEFT/RIGHT). A fresh press emits one move, a held
// key auto-repeats after HOLD_CYCLES and then every REPEAT_CYCLES, and the
// moves are queued in a 4-deep FIFO with a ready/valid consumer handshake
// and a sticky overflow flag for moves dropped while the queue is full.

module frogger_key_move #(
    parameter int unsigned HOLD_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 10000000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [15:0] keycode_export,
    output logic        move_valid,
    output logic [1:0]  move_dir,
    input  logic        move_ready,
    output logic [2:0]  fifo_count,
    output logic        overflow,
    input  logic        clear_ovf
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    // Terminal counts: the timer runs 0..N-1, so N cycles per interval.
    localparam logic [24:0] HOLD_LAST   = 25'(HOLD_CYCLES - 1);
    localparam logic [24:0] REPEAT_LAST = 25'(REPEAT_CYCLES - 1);

    localparam logic [2:0] FIFO_DEPTH = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_HELD   = 2'b01,
        ST_REPEAT = 2'b10
    } state_e;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [15:0] key_q, key_d;

    logic        up_hit, down_hit, left_hit, right_hit;
    logic        cur_valid;
    logic [1:0]  cur_dir;

    state_e      state_q, state_d;
    logic [24:0] cnt_q, cnt_d;
    logic [1:0]  ldir_q, ldir_d;
    logic [24:0] cnt_last;
    logic        timeout;
    logic        dir_change;

    logic        emit;
    logic [1:0]  emit_dir;

    logic [1:0]  fifo_mem_q [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        overflow_q, overflow_d;

    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        wr_en;
    logic        ovf_set;

    // ------------------------------------------------------------------
    // Keycode sample register
    // ------------------------------------------------------------------

    // Next sample is simply the live PIO value.
    always_comb begin
        key_d = keycode_export;
    end

    // Capture the keycode every cycle; all decoding works off this copy.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values; blocking here would create order-dependent races.
        if (!reset_reset_n) begin
            key_q <= 16'h0000;
        end else begin
            key_q <= key_d;
        end
    end

    // ------------------------------------------------------------------
    // Direction decode with fixed priority UP > DOWN > LEFT > RIGHT
    // ------------------------------------------------------------------

    // A direction is active when either HID byte carries its key code.
    always_comb begin
        up_hit    = (key_q[7:0] == KEY_W) || (key_q[15:8] == KEY_W);
        down_hit  = (key_q[7:0] == KEY_S) || (key_q[15:8] == KEY_S);
        left_hit  = (key_q[7:0] == KEY_A) || (key_q[15:8] == KEY_A);
        right_hit = (key_q[7:0] == KEY_D) || (key_q[15:8] == KEY_D);

        // NOTE: every output of a combinational block gets a default first,
        // so no path through the if-chain can leave it unassigned (no latch).
        cur_valid = 1'b0;
        cur_dir   = DIR_UP;
        if (up_hit) begin
            cur_valid = 1'b1;
            cur_dir   = DIR_UP;
        end else if (down_hit) begin
            cur_valid = 1'b1;
            cur_dir   = DIR_DOWN;
        end else if (left_hit) begin
            cur_valid = 1'b1;
            cur_dir   = DIR_LEFT;
        end else if (right_hit) begin
            cur_valid = 1'b1;
            cur_dir   = DIR_RIGHT;
        end
    end

    // ------------------------------------------------------------------
    // Press / hold / repeat FSM
    // ------------------------------------------------------------------

    // Shared timer terms: HELD waits the hold interval, REPEAT the repeat one.
    always_comb begin
        cnt_last   = (state_q == ST_REPEAT) ? REPEAT_LAST : HOLD_LAST;
        timeout    = (cnt_q == cnt_last);
        dir_change = (cur_dir != ldir_q);
    end

    // State register with the hold/repeat timer and latched direction.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 25'd0;
            ldir_q  <= DIR_UP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ldir_q  <= ldir_d;
        end
    end

    // Next-state logic: a new or changed key restarts the hold interval,
    // a timeout moves to (or stays in) REPEAT, release returns to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ldir_d  = ldir_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cur_valid) begin
                    ldir_d  = cur_dir;
                    cnt_d   = 25'd0;
                    state_d = ST_HELD;
                end
            end

            ST_HELD, ST_REPEAT: begin
                if (!cur_valid) begin
                    cnt_d   = 25'd0;
                    state_d = ST_IDLE;
                end else if (dir_change) begin
                    ldir_d  = cur_dir;
                    cnt_d   = 25'd0;
                    state_d = ST_HELD;
                end else if (timeout) begin
                    cnt_d   = 25'd0;
                    state_d = ST_REPEAT;
                end else begin
                    cnt_d   = cnt_q + 25'd1;
                end
            end

            default: begin
                cnt_d   = 25'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: one-cycle emit strobe with the direction to enqueue.
    always_comb begin
        emit     = 1'b0;
        emit_dir = ldir_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cur_valid) begin
                    emit     = 1'b1;
                    emit_dir = cur_dir;
                end
            end

            ST_HELD, ST_REPEAT: begin
                if (cur_valid) begin
                    if (dir_change) begin
                        emit     = 1'b1;
                        emit_dir = cur_dir;
                    end else if (timeout) begin
                        emit     = 1'b1;
                        emit_dir = ldir_q;
                    end
                end
            end

            default: begin
                emit     = 1'b0;
                emit_dir = ldir_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // 4-entry move FIFO
    // ------------------------------------------------------------------

    // Handshake and full/overflow decisions; a pop frees the slot a
    // same-edge push needs, so push+pop always works when non-empty.
    always_comb begin
        fifo_full = (count_q == FIFO_DEPTH);
        push      = emit;
        pop       = move_valid & move_ready;
        wr_en     = push & (~fifo_full | pop);
        ovf_set   = push & fifo_full & ~pop;
    end

    // Pointer, occupancy and sticky overflow next values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end

        if (wr_en && !pop) begin
            count_d = count_q + 3'd1;
        end else if (pop && !wr_en) begin
            count_d = count_q - 3'd1;
        end

        // A drop on the same edge as a clear request keeps the flag set.
        overflow_d = ovf_set | (overflow_q & ~clear_ovf);
    end

    // FIFO control registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage: written at the tail on an accepted push.
    always_ff @(posedge clk_clk) begin
        // NOTE: the storage array has no reset; stale entries are never
        // visible because move_dir is forced to UP whenever the queue is empty.
        if (wr_en) begin
            fifo_mem_q[wr_ptr_q] <= emit_dir;
        end
    end

    // Consumer-facing outputs; the head is held stable until it is popped.
    always_comb begin
        move_valid = (count_q != 3'd0);
        move_dir   = move_valid ? fifo_mem_q[rd_ptr_q] : DIR_UP;
        fifo_count = count_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_frogger_key_move.sv
// tb_frogger_key_move
// Directed bench for frogger_key_move with HOLD_CYCLES=4, REPEAT_CYCLES=2.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.

module tb_frogger_key_move;

    localparam int unsigned HOLD   = 4;
    localparam int unsigned REPEAT = 2;

    localparam logic [1:0] UP    = 2'b00;
    localparam logic [1:0] DOWN  = 2'b01;
    localparam logic [1:0] LEFT  = 2'b10;
    localparam logic [1:0] RIGHT = 2'b11;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [15:0] keycode_export;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        move_ready;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        clear_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk_clk = ~clk_clk;

    frogger_key_move #(
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REPEAT)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .keycode_export(keycode_export),
        .move_valid    (move_valid),
        .move_dir      (move_dir),
        .move_ready    (move_ready),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .clear_ovf     (clear_ovf)
    );

    // Advance one clock and land 1 ns after the rising edge.
    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    // Short press then release long enough for the FSM to return to IDLE.
    task automatic tap(input logic [15:0] key);
        keycode_export = key;
        step();
        keycode_export = 16'h0000;
        step();
        step();
        step();
    endtask

    task automatic test_reset();
        reset_reset_n  = 1'b0;
        keycode_export = 16'h0000;
        move_ready     = 1'b0;
        clear_ovf      = 1'b0;
        #3;
        checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", move_valid); end
        checks++; if (move_dir !== 2'b00) begin errors++; $display("FAIL reset_dir: got %b expected 00", move_dir); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        step();
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        step();
        step();
        checks++; if (move_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b expected 0", move_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL post_reset_count: got %0d expected 0", fifo_count); end
    endtask

    // One move, 2 cycles after apply, valid for exactly one cycle.
    task automatic test_single_press();
        logic exp_v;
        move_ready     = 1'b1;
        keycode_export = 16'h001A;
        for (int s = 1; s <= 8; s++) begin
            step();
            if (s == 3) keycode_export = 16'h0000;
            exp_v = (s == 2);
            checks++;
            if (move_valid !== exp_v) begin errors++; $display("FAIL single_valid step %0d: got %b expected %b", s, move_valid, exp_v); end
            if (exp_v) begin
                checks++;
                if (move_dir !== UP) begin errors++; $display("FAIL single_dir step %0d: got %b expected %b", s, move_dir, UP); end
            end
        end
    endtask

    // Moves at 2, 6, then every 2 cycles while the key stays down.
    task automatic test_auto_repeat();
        logic exp_v;
        int   moves;
        moves          = 0;
        move_ready     = 1'b1;
        keycode_export = 16'h1A00;
        for (int s = 1; s <= 26; s++) begin
            step();
            if (s == 20) keycode_export = 16'h0000;
            exp_v = (s == 2) || (s >= 6 && s <= 20 && (s % 2) == 0);
            checks++;
            if (move_valid !== exp_v) begin errors++; $display("FAIL repeat_valid step %0d: got %b expected %b", s, move_valid, exp_v); end
            if (move_valid === 1'b1) begin
                moves++;
                checks++;
                if (move_dir !== UP) begin errors++; $display("FAIL repeat_dir step %0d: got %b expected %b", s, move_dir, UP); end
            end
        end
        checks++;
        if (moves != 9) begin errors++; $display("FAIL repeat_total: got %0d expected 9", moves); end
    endtask

    // DOWN wins over RIGHT; switching to RIGHT emits at once and restarts
    // the hold timer, so the next RIGHT comes 4 cycles later, not sooner.
    task automatic test_priority_change();
        logic       exp_v;
        logic [1:0] exp_d;
        move_ready     = 1'b1;
        keycode_export = 16'h0716;
        for (int s = 1; s <= 14; s++) begin
            step();
            if (s == 3) keycode_export = 16'h0700;
            if (s == 9) keycode_export = 16'h0000;
            exp_v = (s == 2) || (s == 5) || (s == 9);
            exp_d = (s == 2) ? DOWN : RIGHT;
            checks++;
            if (move_valid !== exp_v) begin errors++; $display("FAIL prio_valid step %0d: got %b expected %b", s, move_valid, exp_v); end
            if (exp_v) begin
                checks++;
                if (move_dir !== exp_d) begin errors++; $display("FAIL prio_dir step %0d: got %b expected %b", s, move_dir, exp_d); end
            end
        end
    endtask

    // Codes outside W/S/A/D produce nothing.
    task automatic test_ignored_keys();
        move_ready     = 1'b1;
        keycode_export = 16'h2C05;
        for (int s = 1; s <= 8; s++) begin
            step();
            if (s == 4) keycode_export = 16'h0500;
            checks++;
            if (move_valid !== 1'b0) begin errors++; $display("FAIL ignored_valid step %0d: got %b expected 0", s, move_valid); end
        end
        keycode_export = 16'h0000;
        step();
        step();
    endtask

    // Five presses into a stalled queue: four kept in order, fifth dropped.
    task automatic test_backpressure();
        logic [15:0] keys  [5];
        logic [1:0]  order [4];
        keys[0] = 16'h001A; keys[1] = 16'h1600; keys[2] = 16'h0004;
        keys[3] = 16'h0700; keys[4] = 16'h0016;
        order[0] = UP; order[1] = DOWN; order[2] = LEFT; order[3] = RIGHT;
        move_ready = 1'b0;
        for (int i = 0; i < 5; i++) tap(keys[i]);
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_count: got %0d expected 4", fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf: got %b expected 1", overflow); end
        checks++; if (move_dir !== UP) begin errors++; $display("FAIL bp_head: got %b expected %b", move_dir, UP); end
        step();
        step();
        checks++; if (move_valid !== 1'b1 || move_dir !== UP) begin errors++; $display("FAIL bp_stable: got valid=%b dir=%b expected valid=1 dir=%b", move_valid, move_dir, UP); end
        move_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (move_valid !== 1'b1 || move_dir !== order[i]) begin
                errors++;
                $display("FAIL bp_drain %0d: got valid=%b dir=%b expected valid=1 dir=%b", i, move_valid, move_dir, order[i]);
            end
            step();
        end
        checks++; if (move_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL bp_empty: got valid=%b count=%0d expected 0/0", move_valid, fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf_sticky: got %b expected 1", overflow); end
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_clear: got %b expected 0", overflow); end
    endtask

    // Push and pop on the same edge with a full queue, then set-vs-clear.
    task automatic test_simultaneous();
        logic [1:0] order [4];
        order[0] = DOWN; order[1] = LEFT; order[2] = RIGHT; order[3] = UP;
        move_ready = 1'b0;
        tap(16'h001A);
        tap(16'h0016);
        tap(16'h0004);
        tap(16'h0007);
        checks++; if (fifo_count !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL sim_fill: got count=%0d ovf=%b expected 4/0", fifo_count, overflow); end
        keycode_export = 16'h1A00;
        step();
        keycode_export = 16'h0000;
        move_ready     = 1'b1;
        step();
        move_ready     = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL sim_count: got %0d expected 4", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sim_ovf: got %b expected 0", overflow); end
        checks++; if (move_dir !== DOWN) begin errors++; $display("FAIL sim_head: got %b expected %b", move_dir, DOWN); end
        keycode_export = 16'h0004;
        step();
        keycode_export = 16'h0000;
        clear_ovf      = 1'b1;
        step();
        clear_ovf      = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL set_wins: got %b expected 1", overflow); end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL drop_count: got %0d expected 4", fifo_count); end
        step();
        step();
        move_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (move_valid !== 1'b1 || move_dir !== order[i]) begin
                errors++;
                $display("FAIL sim_drain %0d: got valid=%b dir=%b expected valid=1 dir=%b", i, move_valid, move_dir, order[i]);
            end
            step();
        end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL sim_empty: got %0d expected 0", fifo_count); end
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
    endtask

    // Reset in REPEAT with two queued moves; held key is a fresh press after.
    task automatic test_reset_mid_repeat();
        logic exp_v;
        move_ready     = 1'b0;
        keycode_export = 16'h1A00;
        for (int s = 1; s <= 7; s++) step();
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rst_pre_count: got %0d expected 2", fifo_count); end
        #1;
        reset_reset_n = 1'b0;
        #1;
        checks++;
        if (move_valid !== 1'b0 || move_dir !== 2'b00 || fifo_count !== 3'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got valid=%b dir=%b count=%0d ovf=%b expected 0/00/0/0", move_valid, move_dir, fifo_count, overflow);
        end
        move_ready = 1'b1;
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        for (int s = 1; s <= 5; s++) begin
            step();
            exp_v = (s == 2);
            checks++;
            if (move_valid !== exp_v) begin errors++; $display("FAIL rst_fresh step %0d: got %b expected %b", s, move_valid, exp_v); end
            if (exp_v) begin
                checks++;
                if (move_dir !== UP) begin errors++; $display("FAIL rst_fresh_dir: got %b expected %b", move_dir, UP); end
            end
        end
        keycode_export = 16'h0000;
        step();
        step();
        move_ready = 1'b0;
        step();
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL empty_pop: got %0d expected 0", fifo_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_press();
        test_auto_repeat();
        test_priority_change();
        test_ignored_keys();
        test_backpressure();
        test_simultaneous();
        test_reset_mid_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
